// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank slice: clear/ready FSM encoding and byte width.
package ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/ram_clear_ctr.sv
// Post-reset zero-fill sequencer for ram_bank: walks addresses 0..DEPTH-1,
// one per cycle, while busy is high, then parks in READY.
module ram_clear_ctr
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     clr_we
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and clear-write outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

endmodule

// File: rtl/ram_bank.sv
// Byte-writable single-clock RAM bank with optional output register and
// post-reset zero fill. Define RAM_BANK_BYPASS_EN to forward same-cycle
// same-address write bytes into the read data.
module ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH/8-1:0]       wen,
  input  logic [WIDTH-1:0]         din,
  input  logic                     ren,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         dout,
  output logic                     rvalid,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NB = WIDTH / BYTE_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    clr_addr;
  logic             clr_we;
  logic             wr_act;
  logic             rd_act;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] dout_q;
  logic             rv_q;

  ram_clear_ctr #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign wr_act = !busy && !rst;
  assign rd_act = !busy && !rst && ren;

  // Array update: zero fill during CLEAR, byte-enabled writes in READY.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[clr_addr] <= '0;
    end else if (wr_act) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wen[i]) begin
          mem[waddr][i*BYTE_W +: BYTE_W] <= din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word selection (old array contents, optionally merged with write bytes).
  always_comb begin
    rd_word = mem[raddr];
`ifdef RAM_BANK_BYPASS_EN
    if (wr_act && (waddr == raddr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wen[i]) begin
          rd_word[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
        end
      end
    end
`endif
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] s1_data;
      logic             s1_v;

      // Two-stage read pipeline; dout only moves when a read completes.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_v    <= 1'b0;
          s1_data <= '0;
          rv_q    <= 1'b0;
          dout_q  <= '0;
        end else begin
          s1_v <= rd_act;
          if (rd_act) begin
            s1_data <= rd_word;
          end
          rv_q <= s1_v;
          if (s1_v) begin
            dout_q <= s1_data;
          end
        end
      end
    end else begin : g_noreg
      // Single-stage read; dout holds when no read is accepted.
      always_ff @(posedge clk) begin
        if (rst) begin
          rv_q   <= 1'b0;
          dout_q <= '0;
        end else begin
          rv_q <= rd_act;
          if (rd_act) begin
            dout_q <= rd_word;
          end
        end
      end
    end
  endgenerate

  assign dout   = dout_q;
  assign rvalid = rv_q;

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256: number of words; must be a power of two and at least 2.
REQ-003 SHALL have parameter OUT_REG, default 0: value 1 adds one output pipeline stage.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1: value 1 zero-fills the whole array after reset.
REQ-005 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port waddr, input, $clog2(DEPTH) bits: write word address.
REQ-008 SHALL have port wen, input, WIDTH/8 bits: per-byte write enable; bit i writes din[8i+7:8i].
REQ-009 SHALL have port din, input, WIDTH bits: write data.
REQ-010 SHALL have port ren, input, 1 bit: read request.
REQ-011 SHALL have port raddr, input, $clog2(DEPTH) bits: read word address.
REQ-012 SHALL have port dout, output, WIDTH bits: read data.
REQ-013 SHALL have port rvalid, output, 1 bit: one-cycle pulse, aligned with dout, for each accepted read.
REQ-014 SHALL have port busy, output, 1 bit: high while the clear sequence runs.

Function
REQ-015 SHALL use an FSM with states CLEAR and READY; reset enters CLEAR when CLEAR_ON_RESET=1, otherwise READY.
REQ-016 SHALL, in CLEAR, write all-zero to one address per cycle, counting 0 to DEPTH-1, then go to READY; CLEAR takes exactly DEPTH cycles.
REQ-017 SHALL hold busy=1 in CLEAR and 0 in READY.
REQ-018 SHALL ignore wen and ren in CLEAR: no array write and no rvalid.
REQ-019 SHALL, in READY, update only the bytes enabled by wen at waddr; wen=0 writes nothing.
REQ-020 SHALL, in READY, accept a read when ren=1; read latency from the ren edge to dout/rvalid is 1 cycle with OUT_REG=0 and 2 cycles with OUT_REG=1.
REQ-021 SHALL hold dout at its last value when no read completes; rvalid is 0 in those cycles.
REQ-022 SHALL accept back-to-back reads every cycle at full throughput with either OUT_REG value.
REQ-023 SHALL, on a same-cycle read and write to the same address without the bypass feature, return the old word.
REQ-024 SHALL allow a simultaneous read and write to different addresses with no interaction.
REQ-025 SHALL flush in-flight reads (rvalid=0) when rst is asserted mid-pipeline or mid-CLEAR; CLEAR then restarts at address 0.

Reset
REQ-026 SHALL, on a clk edge with rst=1, set dout=0, rvalid=0, clear the pipeline stage, and reset the clear counter to 0.
REQ-027 SHALL set busy=1 after reset when CLEAR_ON_RESET=1, and busy=0 otherwise.
REQ-028 SHALL leave array contents unchanged by rst when CLEAR_ON_RESET=0.

Configuration
REQ-029 SHALL, when macro RAM_BANK_BYPASS_EN is defined, return the merged word on a same-cycle same-address read and write: enabled bytes from din, other bytes from the array.
REQ-030 SHALL, when RAM_BANK_BYPASS_EN is undefined, contain no forwarding logic and behave per REQ-023.

Structure
REQ-031 SHALL place the FSM state enum (CLEAR, READY) and constant BYTE_W=8 in package ram_pkg.
REQ-032 SHALL implement the clear counter and FSM in sub-module ram_clear_ctr, parameterised by DEPTH, with outputs busy, clr_addr and clr_we.

Verification
REQ-033 SHALL test reset clear: rst for 1 cycle with DEPTH=16 -> busy high for exactly 16 cycles, then every read returns 0.
REQ-034 SHALL test byte write: write 0xAABBCCDD with wen=4'b1111, then 0x11223344 with wen=4'b0101, then read -> dout=0xAA22CC44 with rvalid after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-035 SHALL test streaming: ren high for 8 cycles over addresses 0-7 -> 8 consecutive rvalid pulses carrying the correct words in address order.
REQ-036 SHALL test same-address collision: old word 0x0 and a write of 0xFFFFFFFF with wen=4'b0011 in the read cycle -> dout=0x00000000 without the bypass, 0x0000FFFF with RAM_BANK_BYPASS_EN.
REQ-037 SHALL test reset mid-clear: rst at clear address 5 -> the counter restarts at 0 and busy stays high for DEPTH further cycles.
REQ-038 SHALL test reads during busy: ren=1 in CLEAR -> no rvalid, and dout stays at 0.
